instruction_fetch_unit: RTL

- Fetch stage directly upstream of the instruction decoder: holds the word-addressed PC and reads a synchronous instruction memory (1-cycle read latency).
- Presents one 32-bit instruction per cycle on ins/ins_valid to the decoder, with a stall/hold handshake and branch/jump/RET redirect with flush.
- Detects HALT (opcode 6'b010110), delivers it downstream, then stops fetching until reset.

---
 rtl/instruction_fetch_unit.sv | 61 ++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC + synchronous imem fetch with stall hold, redirect flush and HALT stop
module instruction_fetch_unit #(
  parameter int ADDR_W = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       ins,
  output logic [ADDR_W-1:0] ins_pc,
  output logic              ins_valid,
  output logic              halted
);
  localparam logic [5:0] OP_HALT = 6'b010110;
  typedef enum logic {RUN, HALTED} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] pc, req_pc;
  logic req_vld, advance, redir, halt_cap, issue;
  always_comb begin
    advance  = !stall || !ins_valid;
    redir    = redirect_valid && state == RUN;
    halt_cap = req_vld && imem_rdata[31:26] == OP_HALT;
    issue    = !rst && !redir && advance && state == RUN && !halt_cap;
    state_n  = (!redir && advance && halt_cap) ? HALTED : state;
  end
  assign imem_en   = issue;
  assign imem_addr = pc;
  assign halted    = state == HALTED;
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      req_vld   <= 1'b0;
      req_pc    <= '0;
      ins       <= '0;
      ins_pc    <= '0;
      ins_valid <= 1'b0;
    end else if (redir) begin
      pc        <= redirect_pc;
      req_vld   <= 1'b0;
      ins_valid <= 1'b0;
    end else if (advance) begin
      ins       <= imem_rdata;
      ins_pc    <= req_pc;
      ins_valid <= req_vld;
      req_vld   <= issue;
      if (issue) begin
        req_pc <= pc;
        pc     <= pc + 1'b1;
      end
    end
  end
endmodule
